// File: rtl/ym2149_pkg.sv
// rtl/ym2149_pkg.sv - shared types and constants for the YM2149 bus controller
package ym2149_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GUARD,
      ST_DATA
   } state_t;

   // {BDIR, BC} encodings
   localparam logic [1:0] BUS_INACT = 2'b00;
   localparam logic [1:0] BUS_ADDR  = 2'b11;
   localparam logic [1:0] BUS_WRITE = 2'b10;
   localparam logic [1:0] BUS_READ  = 2'b01;

   localparam logic [3:0] R_TONE_A_LO = 4'd0;
   localparam logic [3:0] R_TONE_A_HI = 4'd1;
   localparam logic [3:0] R_TONE_B_LO = 4'd2;
   localparam logic [3:0] R_TONE_B_HI = 4'd3;
   localparam logic [3:0] R_TONE_C_LO = 4'd4;
   localparam logic [3:0] R_TONE_C_HI = 4'd5;
   localparam logic [3:0] R_NOISE     = 4'd6;
   localparam logic [3:0] R_MIXER     = 4'd7;
   localparam logic [3:0] R_AMP_A     = 4'd8;
   localparam logic [3:0] R_AMP_B     = 4'd9;
   localparam logic [3:0] R_AMP_C     = 4'd10;
   localparam logic [3:0] R_ENV_LO    = 4'd11;
   localparam logic [3:0] R_ENV_HI    = 4'd12;
   localparam logic [3:0] R_ENV_SHAPE = 4'd13;
   localparam logic [3:0] R_IO_A      = 4'd14;
   localparam logic [3:0] R_IO_B      = 4'd15;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer advances on accept
module rr_arb2 (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [1:0] REQ,
   input  logic       ACCEPT,
   output logic [1:0] GRANT
);

   logic last_port;

   always_comb begin
      GRANT = REQ;
      if (REQ == 2'b11) GRANT = last_port ? 2'b01 : 2'b10;
   end

   // Reset to "port 1 served last" so port 0 wins the first contention.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         last_port <= 1'b1;
      else if (ACCEPT && GRANT != 2'b00)
         last_port <= GRANT[1];
   end

endmodule

// File: rtl/ym2149_bus_ctrl.sv
// rtl/ym2149_bus_ctrl.sv - two-port YM2149 bus controller with CE-paced ADDR/GUARD/DATA cycles
module ym2149_bus_ctrl
   import ym2149_pkg::*;
#(
   parameter int PHASE_CYC = 2,
   parameter int GUARD_CYC = 1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE,
   input  logic       REQ0_VALID,
   output logic       REQ0_READY,
   input  logic       REQ0_WR,
   input  logic [3:0] REQ0_ADDR,
   input  logic [7:0] REQ0_WDATA,
   input  logic       REQ1_VALID,
   output logic       REQ1_READY,
   input  logic       REQ1_WR,
   input  logic [3:0] REQ1_ADDR,
   input  logic [7:0] REQ1_WDATA,
   output logic       RSP0_VALID,
   output logic [7:0] RSP0_RDATA,
   output logic       RSP1_VALID,
   output logic [7:0] RSP1_RDATA,
   output logic       BDIR,
   output logic       BC,
   output logic [7:0] DI,
   input  logic [7:0] DO,
   output logic       BUSY
);

   state_t     state;
   logic [7:0] cnt;
   logic       cnt_last;
   logic       accept;
   logic [1:0] grant;
   logic       lat_port;
   logic       lat_wr;
   logic [3:0] lat_addr;
   logic [7:0] lat_wdata;

   assign accept     = RESET_N && (state == ST_IDLE) && (REQ0_VALID || REQ1_VALID);
   assign REQ0_READY = accept && grant[0];
   assign REQ1_READY = accept && grant[1];
   assign BUSY       = (state != ST_IDLE);

   rr_arb2 u_arb (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .REQ    ({REQ1_VALID, REQ0_VALID}),
      .ACCEPT (accept),
      .GRANT  (grant)
   );

   always_comb begin
      if (state == ST_GUARD) cnt_last = (cnt == 8'(GUARD_CYC - 1));
      else                   cnt_last = (cnt == 8'(PHASE_CYC - 1));
   end

   // Bus outputs are loaded on the edge entering each state so they are glitch-free.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat_port   <= 1'b0;
         lat_wr     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         {BDIR, BC} <= BUS_INACT;
         DI         <= '0;
         RSP0_VALID <= 1'b0;
         RSP1_VALID <= 1'b0;
         RSP0_RDATA <= '0;
         RSP1_RDATA <= '0;
      end else begin
         RSP0_VALID <= 1'b0;
         RSP1_VALID <= 1'b0;
         if (state == ST_IDLE) begin
            if (accept) begin
               lat_port   <= grant[1];
               lat_wr     <= grant[1] ? REQ1_WR    : REQ0_WR;
               lat_addr   <= grant[1] ? REQ1_ADDR  : REQ0_ADDR;
               lat_wdata  <= grant[1] ? REQ1_WDATA : REQ0_WDATA;
               DI         <= {4'b0, grant[1] ? REQ1_ADDR : REQ0_ADDR};
               {BDIR, BC} <= BUS_ADDR;
               cnt        <= '0;
               state      <= ST_ADDR;
            end
         end else if (CE) begin
            if (!cnt_last) begin
               cnt <= cnt + 8'd1;
            end else begin
               cnt <= '0;
               case (state)
                  ST_ADDR: begin
                     {BDIR, BC} <= BUS_INACT;
                     state      <= ST_GUARD;
                  end
                  ST_GUARD: begin
                     {BDIR, BC} <= lat_wr ? BUS_WRITE : BUS_READ;
                     DI         <= lat_wr ? lat_wdata : 8'h00;
                     state      <= ST_DATA;
                  end
                  default: begin
                     {BDIR, BC} <= BUS_INACT;
                     DI         <= '0;
                     state      <= ST_IDLE;
                     if (lat_port) begin
                        RSP1_VALID <= 1'b1;
                        if (!lat_wr) RSP1_RDATA <= DO;
                     end else begin
                        RSP0_VALID <= 1'b1;
                        if (!lat_wr) RSP0_RDATA <= DO;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ym2149_bus_ctrl.sv
// tb/tb_ym2149_bus_ctrl.sv - self-checking bench for ym2149_bus_ctrl
module tb_ym2149_bus_ctrl;

   localparam int PC = 2;
   localparam int GC = 1;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       CE = 1'b0;
   logic       REQ0_VALID = 1'b0, REQ0_WR = 1'b0;
   logic [3:0] REQ0_ADDR = '0;
   logic [7:0] REQ0_WDATA = '0;
   logic       REQ1_VALID = 1'b0, REQ1_WR = 1'b0;
   logic [3:0] REQ1_ADDR = '0;
   logic [7:0] REQ1_WDATA = '0;
   logic       REQ0_READY, REQ1_READY;
   logic       RSP0_VALID, RSP1_VALID;
   logic [7:0] RSP0_RDATA, RSP1_RDATA;
   logic       BDIR, BC, BUSY;
   logic [7:0] DI;
   logic [7:0] DO = '0;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         rr_last = 1;
   logic [7:0] exp_rdata [2];
   bit         t_wr [2];
   logic [3:0] t_addr [2];
   logic [7:0] t_wdata [2];
   int         ce_phase = 0;

   always #5 CLK = ~CLK;

   ym2149_bus_ctrl #(.PHASE_CYC(PC), .GUARD_CYC(GC)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WR(REQ0_WR),
      .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WR(REQ1_WR),
      .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
      .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
      .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
      .BDIR(BDIR), .BC(BC), .DI(DI), .DO(DO), .BUSY(BUSY)
   );

   // One transaction; the expected bus phase follows from CE pulses counted since the handshake.
   task automatic do_txn(input bit v0, input bit v1, input logic [7:0] dov,
                         input int ce_period, input int freeze_k);
      int  w;
      int  n;
      bit  done;
      bit  ce_now;
      bit  frozen;
      logic [1:0] eb;
      logic [7:0] ed;
      w = (v0 && v1) ? 1 - rr_last : (v1 ? 1 : 0);
      REQ0_VALID = v0; REQ0_WR = t_wr[0]; REQ0_ADDR = t_addr[0]; REQ0_WDATA = t_wdata[0];
      REQ1_VALID = v1; REQ1_WR = t_wr[1]; REQ1_ADDR = t_addr[1]; REQ1_WDATA = t_wdata[1];
      DO = dov;
      #1;
      checks++;
      if (REQ0_READY !== (w == 0) || REQ1_READY !== (w == 1)) begin
         errors++;
         $display("FAIL grant: ready0=%0b ready1=%0b, required port %0d only", REQ0_READY, REQ1_READY, w);
      end
      rr_last = w;
      @(posedge CLK);
      @(negedge CLK);
      if (w == 0) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
      n = 0;
      done = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         if (n >= 2*PC + GC) begin
            done = 1;
            if (!t_wr[w]) exp_rdata[w] = dov;
            checks++;
            if ({RSP1_VALID, RSP0_VALID} !== ((w == 1) ? 2'b10 : 2'b01) || BUSY !== 1'b0 || {BDIR, BC} !== 2'b00) begin
               errors++;
               $display("FAIL completion: rsp1/rsp0=%b%b busy=%b bus=%b%b, required rsp for port %0d, idle bus",
                        RSP1_VALID, RSP0_VALID, BUSY, BDIR, BC, w);
            end
            checks++;
            if (RSP0_RDATA !== exp_rdata[0] || RSP1_RDATA !== exp_rdata[1]) begin
               errors++;
               $display("FAIL rdata: got %h/%h, required %h/%h", RSP0_RDATA, RSP1_RDATA, exp_rdata[0], exp_rdata[1]);
            end
         end else begin
            eb = (n < PC) ? 2'b11 : (n < PC + GC) ? 2'b00 : (t_wr[w] ? 2'b10 : 2'b01);
            ed = (n < PC + GC) ? {4'h0, t_addr[w]} : (t_wr[w] ? t_wdata[w] : 8'h00);
            checks++;
            if ({BDIR, BC} !== eb || DI !== ed || BUSY !== 1'b1 || RSP0_VALID !== 1'b0 || RSP1_VALID !== 1'b0 ||
                REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 ||
                RSP0_RDATA !== exp_rdata[0] || RSP1_RDATA !== exp_rdata[1]) begin
               errors++;
               $display("FAIL phase k=%0d pulses=%0d: bus=%b%b di=%h busy=%b rsp=%b%b rdy=%b%b, required bus=%b di=%h busy=1 rsp=00 rdy=00",
                        k, n, BDIR, BC, DI, BUSY, RSP1_VALID, RSP0_VALID, REQ1_READY, REQ0_READY, eb, ed);
            end
            frozen = (k >= freeze_k) && (k < freeze_k + 20);
            ce_now = frozen ? 1'b0 : ((ce_phase % ce_period) == 0);
            if (!frozen) ce_phase++;
            CE = ce_now;
            @(posedge CLK);
            if (ce_now) n++;
            @(negedge CLK);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: transaction for port %0d never completed", w);
      end
   endtask

   task automatic test_reset();
      REQ0_VALID = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({BDIR, BC} !== 2'b00 || DI !== 8'h00 || BUSY !== 1'b0 || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 ||
          RSP0_VALID !== 1'b0 || RSP1_VALID !== 1'b0 || RSP0_RDATA !== 8'h00 || RSP1_RDATA !== 8'h00) begin
         errors++;
         $display("FAIL reset: bus=%b%b di=%h busy=%b rdy=%b%b rsp=%b%b rdata=%h/%h, required all zero",
                  BDIR, BC, DI, BUSY, REQ1_READY, REQ0_READY, RSP1_VALID, RSP0_VALID, RSP0_RDATA, RSP1_RDATA);
      end
      REQ0_VALID = 1'b0;
      RESET_N = 1'b1;
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
      rr_last = 1;
      @(negedge CLK);
   endtask

   task automatic test_write();
      t_wr[0] = 1'b1; t_addr[0] = 4'd7; t_wdata[0] = 8'h38;
      do_txn(1'b1, 1'b0, 8'h00, 1, 1000);
   endtask

   task automatic test_read();
      t_wr[1] = 1'b0; t_addr[1] = 4'd14; t_wdata[1] = 8'h00;
      do_txn(1'b0, 1'b1, 8'hA5, 1, 1000);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         for (int p = 0; p < 2; p++) begin
            t_wr[p] = 1'($urandom_range(0, 1));
            t_addr[p] = 4'($urandom);
            t_wdata[p] = 8'($urandom);
         end
         do_txn(1'b1, 1'b1, 8'($urandom), 1, 1000);
      end
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
   endtask

   task automatic test_slow_ce();
      ce_phase = 0;
      t_wr[0] = 1'b1; t_addr[0] = 4'($urandom); t_wdata[0] = 8'($urandom);
      do_txn(1'b1, 1'b0, 8'h00, 4, 1000);
      t_wr[1] = 1'b0; t_addr[1] = 4'($urandom);
      do_txn(1'b0, 1'b1, 8'($urandom), 4, 1000);
      t_wr[0] = 1'b1; t_addr[0] = 4'($urandom); t_wdata[0] = 8'($urandom);
      do_txn(1'b1, 1'b0, 8'h00, 1, 1);
   endtask

   task automatic test_random();
      int v;
      for (int i = 0; i < 10; i++) begin
         for (int p = 0; p < 2; p++) begin
            t_wr[p] = 1'($urandom_range(0, 1));
            t_addr[p] = 4'($urandom);
            t_wdata[p] = 8'($urandom);
         end
         v = $urandom_range(1, 3);
         do_txn(v[0], v[1], 8'($urandom), $urandom_range(1, 3), 1000);
         REQ0_VALID = 1'b0;
         REQ1_VALID = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      REQ1_VALID = 1'b0;
      REQ0_VALID = 1'b1; REQ0_WR = 1'b1; REQ0_ADDR = 4'd3; REQ0_WDATA = 8'h5A;
      CE = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ0_VALID = 1'b0;
      for (int k = 0; k < 20 && !(BDIR === 1'b1 && BC === 1'b0); k++) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      checks++;
      if (BDIR !== 1'b1 || BC !== 1'b0 || DI !== 8'h5A) begin
         errors++;
         $display("FAIL reach_data: bus=%b%b di=%h, required 10 with di=5a", BDIR, BC, DI);
      end
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if ({BDIR, BC} !== 2'b00 || DI !== 8'h00 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: bus=%b%b di=%h busy=%b, required 00/00/0", BDIR, BC, DI, BUSY);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         checks++;
         if (RSP0_VALID !== 1'b0 || RSP1_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_rsp: rsp=%b%b busy=%b, required 00/0", RSP1_VALID, RSP0_VALID, BUSY);
         end
      end
      RESET_N = 1'b1;
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
      rr_last = 1;
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
         t_wr[p] = 1'($urandom_range(0, 1));
         t_addr[p] = 4'($urandom);
         t_wdata[p] = 8'($urandom);
      end
      do_txn(1'b1, 1'b1, 8'($urandom), 1, 1000);
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
   endtask

   initial begin
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_slow_ce();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ym2149_bus_ctrl.md
Name: ym2149_bus_ctrl

Overview:
- Bus controller that owns the BDIR/BC/DI/DO interface of the YM2149 PSG and shares it between two requesters: port 0 (CPU I/O path) and port 1 (music replayer/DMA).
- Arbitrates round-robin and runs a CE-paced three-phase cycle for each transaction: latch address, guard, then data write or read.
- Returns a response with the read data to the requester that issued the transaction.

Parameters:
- PHASE_CYC, 2, CE pulses spent in each ADDR and DATA phase (≥1).
- GUARD_CYC, 1, CE pulses of bus-inactive between ADDR and DATA (≥1).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- CE  in  1  PSG clock enable; all phase timing counts CE pulses
- REQn_VALID  in  1  request valid, n=0,1
- REQn_READY  out  1  request accepted this cycle
- REQn_WR  in  1  1=write, 0=read
- REQn_ADDR  in  4  PSG register index 0..15
- REQn_WDATA  in  8  write data
- RSPn_VALID  out  1  one-cycle completion pulse
- RSPn_RDATA  out  8  last read data for port n
- BDIR  out  1  PSG bus direction
- BC  out  1  PSG bus control
- DI  out  8  data/address to PSG
- DO  in  8  data from PSG
- BUSY  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, while RESET_N=0):
  - State IDLE; BDIR=BC=0, DI=0, all READY/RSP_VALID=0, RSPn_RDATA=0, BUSY=0.
  - Round-robin pointer favours port 0.
  - A reset mid-transaction aborts it immediately. No response is issued.
- Bus encodings: ADDR = BDIR/BC 1/1; DATA write = 1/0; DATA read = 0/1; IDLE and GUARD = 0/0.
- Arbitration in IDLE:
  - REQn_READY is combinational: asserted for the granted port only when its VALID=1 and state=IDLE.
  - If both ports are valid, grant the port not granted last. If one is valid, grant it.
  - The pointer updates on each handshake.
  - On the handshake edge, latch WR/ADDR/WDATA and the port id. The state moves to ADDR.
- States: IDLE → ADDR → GUARD → DATA → IDLE.
  - Per-state counter counts CE pulses. A state exits on the clock edge where CE=1 and count=len−1.
  - If CE=0, the FSM holds and bus outputs are stable.
  - ADDR: DI={4'b0,addr}, BDIR/BC=1/1, duration PHASE_CYC pulses.
  - GUARD: BDIR/BC=0/0, DI holds address, duration GUARD_CYC pulses.
  - DATA write: DI=wdata, BDIR/BC=1/0, duration PHASE_CYC pulses.
  - DATA read: DI=0, BDIR/BC=0/1. DO is sampled on the exit edge into RSPn_RDATA.
- Completion:
  - On the DATA exit edge, RSPn_VALID for the latched port is registered high for exactly one cycle, for both writes and reads.
  - RSPn_RDATA changes only on reads and holds between reads.
- Timing:
  - With CE=1, PHASE_CYC=2, GUARD_CYC=1: ADDR occupies cycles 1–2 after the handshake, GUARD cycle 3, DATA cycles 4–5, and RSP_VALID is high in cycle 6.
  - IDLE lasts at least one cycle (cycle 6), so the next handshake is possible in cycle 6.
- BUSY = (state≠IDLE).
- A requester may drop VALID before READY. No request is latched without a handshake.

Decomposition:
- Package ym2149_pkg:
  - State enum (IDLE, ADDR, GUARD, DATA).
  - Bus encoding constants BUS_INACT, BUS_ADDR, BUS_WRITE, BUS_READ.
  - Register index constants R_TONE_A_LO..R_IO_B.
- Sub-module rr_arb2: two-way round-robin arbiter with grant and pointer update on accept, reused elsewhere.
- FSM, phase counter and response registers stay in the top module.

Test Plan:
- Port 0 writes reg 7 = 0x38, CE=1:
  - Cycles 1–2: BDIR/BC=11, DI=0x07.
  - Cycle 3: 00.
  - Cycles 4–5: 10, DI=0x38.
  - Cycle 6: RSP0_VALID=1. RSP1_VALID stays 0.
- Port 1 reads reg 14 with DO=0xA5:
  - DATA phase drives BDIR/BC=01.
  - RSP1_VALID pulses with RSP1_RDATA=0xA5. RSP0_RDATA is unchanged.
- Both ports hold VALID for 4 transactions: grants in order 0,1,0,1. Exactly one READY is asserted per handshake, and never while BUSY.
- CE pulses every 4th clock: each phase lasts 4× as long in clocks, and bus outputs are constant between CE pulses. Holding CE=0 for 20 clocks mid-ADDR freezes the state.
- RESET_N asserted mid-DATA write: BDIR/BC=00, DI=0, BUSY=0 immediately, with no RSP pulse. After release, port 0 wins a simultaneous request.
- Integrated with the YM2149 model: port 0 writes reg 0=0x10, reg 7=0x3E, reg 8=0x0F → CHANNEL_A becomes non-zero and toggles.
